// File: rtl/pmod_pkg.sv
// Shared PMOD definitions used by both the button input block and the LED driver.
package pmod_pkg;

    localparam int unsigned PMOD_W = 8;

    // Logical bit i is wired to PMOD pin PIN_MAP[i].
    localparam int unsigned PIN_MAP [PMOD_W] = '{1, 3, 5, 7, 0, 2, 4, 6};

    // Per-channel debounce state: STABLE while raw matches btn, PENDING otherwise.
    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/pmod_debounce_bit.sv
// One debounce channel: accepts a new level after DEBOUNCE_CYCLES consecutive
// mismatched samples and emits a one-cycle press or release strobe.
module pmod_debounce_bit
    import pmod_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic btn,
    output logic press,
    output logic rel
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    db_state_e     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          btn_nxt;
    logic          press_nxt;
    logic          rel_nxt;

    // Next-state: count while mismatched, accept on the last count, clear on match.
    always_comb begin
        cnt_nxt   = '0;
        btn_nxt   = btn;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        state     = (raw != btn) ? DB_PENDING : DB_STABLE;
        case (state)
            DB_STABLE: begin
                cnt_nxt = '0;
            end
            DB_PENDING: begin
                if (cnt == CNT_LAST) begin
                    btn_nxt   = raw;
                    press_nxt = raw;
                    rel_nxt   = ~raw;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    // Channel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            btn   <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            btn   <= btn_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

endmodule

// File: rtl/pmod_btn.sv
// PMOD pushbutton input: two-flop synchronizer, pin remap/inversion, per-bit
// debounce, sticky press events and an interrupt line.
module pmod_btn
    import pmod_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PMOD_W-1:0] pmod,
    output logic [PMOD_W-1:0] btn,
    output logic [PMOD_W-1:0] press,
    output logic [PMOD_W-1:0] rel,
    output logic [PMOD_W-1:0] evt,
    input  logic [PMOD_W-1:0] evt_clr,
    output logic              irq
);

    logic [PMOD_W-1:0] s1;
    logic [PMOD_W-1:0] s2;
    logic [PMOD_W-1:0] raw;
    logic [PMOD_W-1:0] evt_nxt;

    // Two-flop synchronizer; reset to the released (pulled-high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= pmod;
            s2 <= s1;
        end
    end

    // Remap to logical order, invert to active-high, and debounce each channel.
    for (genvar i = 0; i < PMOD_W; i++) begin : g_ch
        assign raw[i] = ~s2[PIN_MAP[i]];

        pmod_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .btn   (btn[i]),
            .press (press[i]),
            .rel   (rel[i])
        );
    end

    // Sticky events: a press on the same cycle as a clear wins.
    always_comb begin
        evt_nxt = (evt & ~evt_clr) | press;
    end

    // Event register and interrupt, both taken from the same next value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt <= '0;
            irq <= 1'b0;
        end else begin
            evt <= evt_nxt;
            irq <= |evt_nxt;
        end
    end

endmodule

// File: tb/tb_pmod_btn.sv
// Self-checking bench for pmod_btn with a short debounce window.
module tb_pmod_btn;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pmod = 8'hFF;
    logic [7:0] evt_clr = 8'h00;
    logic [7:0] btn;
    logic [7:0] press;
    logic [7:0] rel;
    logic [7:0] evt;
    logic       irq;

    int total = 0;
    int bad   = 0;

    pmod_btn #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .pmod    (pmod),
        .btn     (btn),
        .press   (press),
        .rel     (rel),
        .evt     (evt),
        .evt_clr (evt_clr),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: synchronizer pipeline plus a history of logical raw
    // samples; a bit flips once its last N samples all disagree with btn.
    logic [7:0] m_s1, m_s2, m_btn, m_press, m_rel, m_evt;
    logic       m_irq;
    logic [7:0] hist[$];

    function automatic logic [7:0] remap(input logic [7:0] s);
        return {~s[6], ~s[4], ~s[2], ~s[0], ~s[7], ~s[5], ~s[3], ~s[1]};
    endfunction

    task automatic model_reset();
        m_s1 = 8'hFF; m_s2 = 8'hFF;
        m_btn = 8'h00; m_press = 8'h00; m_rel = 8'h00;
        m_evt = 8'h00; m_irq = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge(input logic [7:0] p, input logic [7:0] c);
        logic [7:0] r, np, nr, ne;
        logic       all_diff;
        r = remap(m_s2);
        hist.push_back(r);
        if (hist.size() > N) void'(hist.pop_front());
        np = 8'h00; nr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (hist.size() == N) begin
                all_diff = 1'b1;
                for (int k = 0; k < int'(N); k++)
                    if (hist[k][i] == m_btn[i]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_btn[i]) nr[i] = 1'b1; else np[i] = 1'b1;
                end
            end
        end
        ne      = (m_evt & ~c) | m_press;
        m_irq   = |ne;
        m_evt   = ne;
        m_btn   = m_btn ^ (np | nr);
        m_press = np;
        m_rel   = nr;
        m_s2    = m_s1;
        m_s1    = p;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check8("btn",   btn,          m_btn);
        check8("press", press,        m_press);
        check8("rel",   rel,          m_rel);
        check8("evt",   evt,          m_evt);
        check8("irq",   {7'b0, irq},  {7'b0, m_irq});
    endtask

    task automatic step(input logic [7:0] p, input logic [7:0] c);
        pmod = p;
        evt_clr = c;
        @(posedge clk);
        model_edge(p, c);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int unsigned cycles, input logic [7:0] p);
        pmod = p;
        evt_clr = 8'h00;
        reset = 1'b1;
        #1;
        model_reset();
        check8("rst_btn", btn, 8'h00);
        check8("rst_evt", evt, 8'h00);
        check8("rst_irq", {7'b0, irq}, 8'h00);
        repeat (cycles) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  pmod;
        logic [7:0]  clr;
        int unsigned hold;
        logic [7:0]  exp_btn;
        logic [7:0]  exp_evt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] seen;
        logic [7:0] p;
        logic [7:0] msk;
        logic       found;
        int unsigned lens[5];

        vecs[0] = '{8'hFF, 8'h00, 3, 8'h00, 8'h00};
        vecs[1] = '{8'hFE, 8'h00, 6, 8'h10, 8'h00};
        vecs[2] = '{8'hFE, 8'h00, 1, 8'h10, 8'h10};
        vecs[3] = '{8'h7E, 8'h00, 7, 8'h18, 8'h18};
        vecs[4] = '{8'hFF, 8'h10, 1, 8'h18, 8'h08};
        vecs[5] = '{8'hFF, 8'h00, 6, 8'h00, 8'h08};
        vecs[6] = '{8'hBF, 8'h00, 7, 8'h80, 8'h88};
        vecs[7] = '{8'hFF, 8'hFF, 7, 8'h00, 8'h00};

        // Idle after reset: nothing ever asserts.
        do_reset(3, 8'hFF);
        seen = 8'h00;
        for (int k = 0; k < 20; k++) begin
            step(8'hFF, 8'h00);
            seen = seen | btn | press | rel | evt | {7'b0, irq};
        end
        check8("idle_quiet", seen, 8'h00);

        // Single press on pmod[1] -> logical 0.
        do_reset(2, 8'hFF);
        for (int k = 1; k <= 5; k++) step(8'hFD, 8'h00);
        check8("p1_btn_before", btn, 8'h00);
        step(8'hFD, 8'h00);
        check8("p1_btn", btn, 8'h01);
        check8("p1_press", press, 8'h01);
        step(8'hFD, 8'h00);
        check8("p1_press_once", press, 8'h00);
        check8("p1_evt", evt, 8'h01);
        check8("p1_irq", {7'b0, irq}, 8'h01);
        for (int k = 1; k <= 6; k++) step(8'hFF, 8'h00);
        check8("p1_rel", rel, 8'h01);
        check8("p1_btn_off", btn, 8'h00);
        check8("p1_evt_kept", evt, 8'h01);
        step(8'hFF, 8'h00);
        check8("p1_rel_once", rel, 8'h00);

        // Table-driven sequence.
        do_reset(2, 8'hFF);
        for (int v = 0; v < 8; v++) begin
            for (int unsigned k = 0; k < vecs[v].hold; k++) step(vecs[v].pmod, vecs[v].clr);
            check8($sformatf("vec%0d_btn", v), btn, vecs[v].exp_btn);
            check8($sformatf("vec%0d_evt", v), evt, vecs[v].exp_evt);
        end

        // Glitches on pmod[0] (logical 4): short pulses rejected, long accepted.
        do_reset(2, 8'hFF);
        lens = '{1, 2, 3, 4, 6};
        for (int g = 0; g < 5; g++) begin
            seen = 8'h00;
            for (int unsigned k = 0; k < lens[g]; k++) begin
                step(8'hFE, 8'h00);
                seen = seen | btn | press | rel;
            end
            for (int k = 0; k < 8; k++) begin
                step(8'hFF, 8'h00);
                seen = seen | btn | press | rel;
            end
            if (lens[g] < N) check8($sformatf("glitch%0d", lens[g]), seen, 8'h00);
            if (lens[g] > N) check8($sformatf("pulse%0d", lens[g]), seen & 8'h10, 8'h10);
        end

        // All pins together: every logical bit on the same cycle.
        do_reset(2, 8'hFF);
        for (int k = 1; k <= 5; k++) step(8'h00, 8'h00);
        check8("all_press_before", press, 8'h00);
        step(8'h00, 8'h00);
        check8("all_btn", btn, 8'hFF);
        check8("all_press", press, 8'hFF);
        step(8'h00, 8'h00);
        check8("all_press_once", press, 8'h00);
        for (int k = 0; k < 7; k++) step(8'hFF, 8'h00);
        check8("all_released", btn, 8'h00);

        // Event clear, then clear coinciding with a press.
        do_reset(2, 8'hFF);
        for (int k = 0; k < 7; k++) step(8'hF5, 8'h00);
        check8("clr_evt03", evt, 8'h03);
        for (int k = 0; k < 6; k++) step(8'hFF, 8'h00);
        step(8'hFF, 8'h01);
        check8("clr_evt02", evt, 8'h02);
        check8("clr_irq", {7'b0, irq}, 8'h01);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(8'hF7, 8'h00);
            if (press[1]) found = 1'b1;
        end
        check8("clr_press_seen", {7'b0, found}, 8'h01);
        step(8'hF7, 8'h02);
        check8("set_wins_evt", evt, 8'h02);
        check8("set_wins_irq", {7'b0, irq}, 8'h01);

        // Reset mid-debounce with the pin held low.
        do_reset(2, 8'hFF);
        for (int k = 0; k < 4; k++) step(8'hFD, 8'h00);
        do_reset(2, 8'hFD);
        check8("mid_rst_btn", btn, 8'h00);
        seen = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            step(8'hFD, 8'h00);
            seen = seen | press;
        end
        check8("mid_rst_no_early", seen, 8'h00);
        step(8'hFD, 8'h00);
        check8("mid_rst_press", press, 8'h01);

        // Randomized bouncing inputs against the model.
        do_reset(2, 8'hFF);
        p = 8'hFF;
        for (int k = 0; k < 3000; k++) begin
            msk = 8'h00;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 9) == 0) msk[b] = 1'b1;
            p = p ^ msk;
            if ($urandom_range(0, 399) == 0)
                do_reset($urandom_range(1, 3), p);
            else
                step(p, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
